// File: rtl/maxpool_9bit_seq.sv
// ----------------------------------------------------------------------------
// maxpool_9bit_seq
//   Folds a window of cfg_len sign-magnitude values through one shared max
//   comparator, one value per accepted beat, and presents the window maximum
//   on a valid/ready result port. Sits between the PE/activation output
//   stream and the pooling write-back.
//
//   Data format: bit 8 = sign (1 = negative), bits 7:0 = magnitude.
//   Any non-negative value outranks any negative one, so +0 > -0.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   start      request to begin a window, honoured only in IDLE
//   cfg_len    window length (1..MAX_LEN), captured on an accepted start
//   abort      drops the current window and returns to IDLE
//   busy       high while a window is accumulating or waiting to be read
//   cfg_err    one-cycle pulse when a start is rejected for a bad cfg_len
//   in_data    sign-magnitude operand
//   in_valid   in_data valid
//   in_ready   operand accepted (high only while accumulating)
//   out_data   window maximum, held until taken
//   out_valid  result available
//   out_ready  downstream takes out_data
// ----------------------------------------------------------------------------
module maxpool_9bit_seq #(
    parameter int MAX_LEN = 64,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             abort,
    output logic             busy,
    output logic             cfg_err,
    input  logic [8:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [8:0]       out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        OUT   = 2'd2
    } state_t;

    localparam logic [LEN_W-1:0] MAX_LEN_C = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] ONE_C     = LEN_W'(1);

    state_t           state;
    logic [8:0]       acc;
    logic [LEN_W-1:0] cnt;
    logic [LEN_W-1:0] len;

    logic             beat;
    logic             len_ok;
    logic [8:0]       folded;

    // Sign-magnitude maximum; on a tie both operands are bit-identical.
    function automatic logic [8:0] sm_max(input logic [8:0] a, input logic [8:0] b);
        if (a[8] != b[8])
            return a[8] ? b : a;
        else if (!a[8])
            return (a[7:0] >= b[7:0]) ? a : b;
        else
            return (a[7:0] <= b[7:0]) ? a : b;
    endfunction

    assign beat   = in_valid && in_ready;
    assign len_ok = (cfg_len != '0) && (cfg_len <= MAX_LEN_C);
    // The first beat of a window seeds the accumulator instead of comparing
    // against whatever acc held before.
    assign folded = (cnt == '0) ? in_data : sm_max(acc, in_data);

    // NOTE: every register here uses <= so all of them update from the same
    // pre-edge values; mixing in blocking writes would make order matter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            len       <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b0;
            busy      <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            cfg_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (len_ok) begin
                            len      <= cfg_len;
                            cnt      <= '0;
                            state    <= ACCUM;
                            in_ready <= 1'b1;
                            busy     <= 1'b1;
                        end else begin
                            cfg_err <= 1'b1;
                        end
                    end
                end

                ACCUM: begin
                    if (abort) begin
                        state    <= IDLE;
                        in_ready <= 1'b0;
                        busy     <= 1'b0;
                        acc      <= '0;
                        cnt      <= '0;
                    end else if (beat) begin
                        cnt <= cnt + ONE_C;
                        if (cnt == len - ONE_C) begin
                            out_data  <= folded;
                            out_valid <= 1'b1;
                            in_ready  <= 1'b0;
                            state     <= OUT;
                        end else begin
                            acc <= folded;
                        end
                    end
                end

                OUT: begin
                    // abort outranks a handshake in the same cycle; either
                    // way the result is released and the window is closed.
                    if (abort || out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        acc       <= '0;
                        cnt       <= '0;
                    end
                end

                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_maxpool_9bit_seq.sv
// ----------------------------------------------------------------------------
// tb_maxpool_9bit_seq
//   Scoreboard bench for maxpool_9bit_seq. Each complete window pushes its
//   expected maximum when it is driven; a monitor pops and compares on every
//   out_valid && out_ready. Control behaviour (latency, back-pressure,
//   cfg_err, abort, async reset) is checked directly.
// ----------------------------------------------------------------------------
module tb_maxpool_9bit_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [6:0] cfg_len;
    logic       abort;
    logic       busy;
    logic       cfg_err;
    logic [8:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [8:0] out_data;
    logic       out_valid;
    logic       out_ready;

    int n_checks = 0;
    int n_fails  = 0;

    logic [8:0] sb[$];
    logic [8:0] win[$];

    maxpool_9bit_seq dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .cfg_len   (cfg_len),
        .abort     (abort),
        .busy      (busy),
        .cfg_err   (cfg_err),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Rank on a plain integer line: +m -> 2m, -m -> -2m-1, so -0 sits just
    // below +0 and negative magnitudes order in reverse.
    function automatic int rank(input logic [8:0] v);
        if (v[8]) return -2 * int'(v[7:0]) - 1;
        return 2 * int'(v[7:0]);
    endfunction

    task automatic push_expected();
        logic [8:0] best;
        best = win[0];
        foreach (win[i])
            if (rank(win[i]) > rank(best)) best = win[i];
        sb.push_back(best);
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic start_window(input int len);
        start   = 1'b1;
        cfg_len = 7'(len);
        cycle();
        start   = 1'b0;
    endtask

    task automatic beat(input logic [8:0] d);
        in_valid = 1'b1;
        in_data  = d;
        cycle();
        in_valid = 1'b0;
    endtask

    // Drive the whole of win[], optionally inserting bubbles after beat bub_at.
    task automatic run_window(input int bub_at, input int nbub);
        push_expected();
        start_window(win.size());
        foreach (win[i]) begin
            beat(win[i]);
            if (i == bub_at) repeat (nbub) cycle();
        end
    endtask

    task automatic drain(input string tag);
        int k;
        k = 0;
        while (sb.size() != 0 && k < 20) begin
            cycle();
            k++;
        end
        check(tag, sb.size(), 0);
        cycle();
    endtask

    // Monitor: compare every delivered result against the scoreboard head.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_out", out_data, 9'h1ff);
            end else begin
                check("out_data", out_data, sb.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [8:0] held;

        rst = 1'b1; start = 1'b0; cfg_len = '0; abort = 1'b0;
        in_data = '0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (2) cycle();
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_cfg_err", cfg_err, 0);
        rst = 1'b0;
        cycle();

        // 1: mixed signs, back-to-back, one-cycle latency
        win = '{9'h103, 9'h005, 9'h0FF, 9'h110};
        push_expected();
        start_window(4);
        check("t1_in_ready", in_ready, 1);
        beat(win[0]); beat(win[1]); beat(win[2]);
        check("t1_no_early_valid", out_valid, 0);
        beat(win[3]);
        check("t1_latency_valid", out_valid, 1);
        check("t1_out_data", out_data, 9'h0FF);
        drain("t1_drain");

        // 2: all negative, signed zero, single-beat window
        win = '{9'h1FF, 9'h102, 9'h180};
        run_window(-1, 0);
        drain("t2a_drain");
        win = '{9'h100, 9'h000};
        run_window(-1, 0);
        drain("t2b_drain");
        win = '{9'h000, 9'h100};
        run_window(-1, 0);
        drain("t2c_drain");
        win = '{9'h1FF};
        run_window(-1, 0);
        drain("t2d_drain");

        // 3: bubbles between beats 2 and 3
        win = '{9'h011, 9'h122, 9'h033, 9'h02A};
        push_expected();
        start_window(4);
        beat(win[0]); beat(win[1]);
        repeat (3) cycle();
        check("t3_bubble_in_ready", in_ready, 1);
        check("t3_bubble_no_valid", out_valid, 0);
        beat(win[2]);
        check("t3_third_no_valid", out_valid, 0);
        beat(win[3]);
        check("t3_valid_after_4th", out_valid, 1);
        drain("t3_drain");

        // 4: back-pressure holds the result; start during OUT is ignored
        win = '{9'h140, 9'h07E, 9'h07F};
        push_expected();
        out_ready = 1'b0;
        start_window(3);
        foreach (win[i]) beat(win[i]);
        held = out_data;
        for (int c = 0; c < 5; c++) begin
            check("t4_hold_valid", out_valid, 1);
            check("t4_hold_data", out_data, 9'h07F);
            check("t4_hold_in_ready", in_ready, 0);
            check("t4_hold_stable", out_data, held);
            if (c == 2) begin
                start   = 1'b1;
                cfg_len = 7'd2;
            end
            cycle();
            start = 1'b0;
        end
        out_ready = 1'b1;
        cycle();
        check("t4_idle_busy", busy, 0);
        check("t4_idle_valid", out_valid, 0);
        cycle();
        check("t4_start_ignored", busy, 0);
        check("t4_sb_empty", sb.size(), 0);

        // 5: illegal lengths, then the longest legal window
        start_window(0);
        check("t5_len0_err", cfg_err, 1);
        check("t5_len0_busy", busy, 0);
        cycle();
        check("t5_len0_pulse", cfg_err, 0);
        start_window(65);
        check("t5_len65_err", cfg_err, 1);
        check("t5_len65_busy", busy, 0);
        cycle();
        check("t5_len65_pulse", cfg_err, 0);
        check("t5_still_idle", busy, 0);
        win = {};
        for (int i = 0; i < 64; i++) win.push_back(9'($urandom_range(0, 511)));
        run_window(-1, 0);
        check("t5_len64_valid", out_valid, 1);
        drain("t5_drain");

        // 6: abort mid-window (same cycle as a beat), then a fresh window
        start_window(4);
        beat(9'h050); beat(9'h060);
        abort    = 1'b1;
        in_valid = 1'b1;
        in_data  = 9'h0F0;
        cycle();
        abort    = 1'b0;
        in_valid = 1'b0;
        check("t6_abort_busy", busy, 0);
        check("t6_abort_in_ready", in_ready, 0);
        check("t6_abort_valid", out_valid, 0);
        repeat (3) cycle();
        check("t6_no_late_valid", out_valid, 0);
        win = '{9'h101, 9'h012, 9'h011, 9'h1AA};
        run_window(-1, 0);
        drain("t6_fresh_drain");

        // abort while holding a result in OUT
        win = '{9'h033};
        out_ready = 1'b0;
        start_window(1);
        beat(win[0]);
        check("t6_out_hold", out_valid, 1);
        abort = 1'b1;
        cycle();
        abort     = 1'b0;
        out_ready = 1'b1;
        check("t6_out_abort_valid", out_valid, 0);
        check("t6_out_abort_busy", busy, 0);

        // async reset mid-ACCUM
        start_window(4);
        beat(9'h077);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("t6_arst_busy", busy, 0);
        check("t6_arst_in_ready", in_ready, 0);
        check("t6_arst_out_valid", out_valid, 0);
        check("t6_arst_out_data", out_data, 0);
        check("t6_arst_cfg_err", cfg_err, 0);
        cycle();
        rst = 1'b0;
        cycle();
        check("t6_arst_idle", busy, 0);
        win = '{9'h002, 9'h004};
        run_window(-1, 0);
        drain("t6_post_rst_drain");

        check("final_sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
